alu_md: RTL
===========

ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width (power of two, at least 8).
REQ-002 SHALL have parameter ROB_POS_WID, default 4, meaning ROB index width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports rdy (input, 1, global stall when low) and rollback (input, 1, flush).
REQ-006 SHALL have ports alu_en (input, 1, issue strobe) and rob_pos (input, ROB_POS_WID, tag).
REQ-007 SHALL have ports opcode (input, 7), funct3 (input, 3), funct7_alt (input, 1, SUB/SRA select) and funct7_m (input, 1, RV32M select).
REQ-008 SHALL have ports val1, val2, imm and pc, each input, XLEN wide, carrying operands, immediate and instruction address.
REQ-009 SHALL have port busy  output  1  high while a multi-cycle op occupies the unit.
REQ-010 SHALL have port result  output  1  one-cycle valid pulse.
REQ-011 SHALL have ports result_rob_pos (output, ROB_POS_WID), result_val (output, XLEN), result_jump (output, 1) and result_pc (output, XLEN).

Function
REQ-012 SHALL implement a state machine with states IDLE, MUL, DIV and DONE.
REQ-013 SHALL accept an issue only when alu_en=1, rdy=1, rollback=0 and busy=0; alu_en while busy=1 is ignored.
REQ-014 SHALL complete base ops (ARITH, ARITHI, BR, JAL, JALR, LUI, AUIPC) with result=1 on the edge after acceptance, i.e. 1-cycle latency.
REQ-015 SHALL use only shamt = operand[log2(XLEN)-1:0] for SLL/SRL/SRA, with SRA sign-filling.
REQ-016 SHALL evaluate BGE as signed >= and BGEU as unsigned >=, and SHALL drive result_val=0 for BR.
REQ-017 SHALL set result_pc to pc+imm (BR taken, JAL), pc+4 (BR not taken) or (val1+imm) with bit0 cleared (JALR), and SHALL drive result_jump=1 for JAL/JALR.
REQ-018 SHALL drive result_jump=0 and result_pc=pc+4 for non-control ops.
REQ-019 SHALL, for opcode ARITH with funct7_m=1 and funct3 0-3 (MUL, MULH, MULHSU, MULHU), enter MUL and perform a radix-2 shift-add of XLEN steps on the 2*XLEN product, one step per rdy-high cycle.
REQ-020 SHALL, for funct7_m=1 and funct3 4-7 (DIV, DIVU, REM, REMU), enter DIV and perform a restoring division of XLEN steps on magnitudes, applying sign correction at the end.
REQ-021 SHALL make MUL and DIV take XLEN cycles followed by DONE, so result pulses on the edge XLEN+1 after acceptance, with busy=1 from the edge after acceptance through DONE.
REQ-022 SHALL return MUL the low XLEN bits and MULH/MULHSU/MULHU the high XLEN bits, using signed*signed, signed*unsigned and unsigned*unsigned operands respectively.
REQ-023 SHALL, on divide by zero, skip iteration and go straight to DONE with quotient all-ones and remainder = val1.
REQ-024 SHALL, on signed overflow (val1 = -2^(XLEN-1), val2 = -1), go straight to DONE with quotient = val1 and remainder = 0.
REQ-025 SHALL leave result=1 for exactly one cycle per completed op and return to IDLE from DONE.
REQ-026 SHALL freeze all registers (state, counter, partials, outputs) while rdy=0, including a pending result pulse.
REQ-027 SHALL, on rollback=1 with rdy=1, force IDLE, busy=0 and result=0 on that edge, discarding any in-flight op and ignoring any same-cycle alu_en.

Reset
REQ-028 SHALL, when rst_n=0 at a rising edge, set state=IDLE, busy=0, result=0, result_rob_pos=0, result_val=0, result_jump=0 and result_pc=0, overriding rdy and rollback.
REQ-029 SHALL have asserting rst_n=0 mid-MUL/DIV abandon the op with no result pulse afterwards.

Verification
REQ-030 SHALL cover: ADD 7+(-3), rob_pos=5 -> next cycle result=1, result_val=4, rob_pos=5, result_jump=0, result_pc=pc+4.
REQ-031 SHALL cover: BGE val1=val2=9, pc=0x100, imm=0x20 -> result_jump=1, result_pc=0x120; SRA 0x80000000 by 31 -> 0xFFFFFFFF.
REQ-032 SHALL cover: MULH 0xFFFFFFFF*0xFFFFFFFF -> 0 and MULHU -> 0xFFFFFFFE, each arriving 33 cycles after issue, with busy high for 33 cycles.
REQ-033 SHALL cover: DIV -7/2 -> -3 and REM -> -1; DIVU x/0 -> 0xFFFFFFFF in 2 cycles; DIV 0x80000000/-1 -> 0x80000000.
REQ-034 SHALL cover: rdy low for 5 cycles mid-DIV -> result delayed exactly 5 cycles with the value unchanged; alu_en while busy -> no effect.
REQ-035 SHALL cover: rollback at cycle 10 of MUL -> no result, busy=0 next cycle, and an immediate new ADD completes normally; rst_n low mid-DIV -> all outputs zero.

Source files
------------

// File: rtl/alu_md.sv
// Integer execution unit: single-cycle RV32I arithmetic/branch/jump ops plus
// iterative RV32M multiply (radix-2 shift-add) and divide (restoring).
module alu_md #(
  parameter int XLEN        = 32,
  parameter int ROB_POS_WID = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rdy,
  input  logic                   rollback,
  input  logic                   alu_en,
  input  logic [ROB_POS_WID-1:0] rob_pos,
  input  logic [6:0]             opcode,
  input  logic [2:0]             funct3,
  input  logic                   funct7_alt,
  input  logic                   funct7_m,
  input  logic [XLEN-1:0]        val1,
  input  logic [XLEN-1:0]        val2,
  input  logic [XLEN-1:0]        imm,
  input  logic [XLEN-1:0]        pc,
  output logic                   busy,
  output logic                   result,
  output logic [ROB_POS_WID-1:0] result_rob_pos,
  output logic [XLEN-1:0]        result_val,
  output logic                   result_jump,
  output logic [XLEN-1:0]        result_pc
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [6:0] OP_ARITH  = 7'b0110011;
  localparam logic [6:0] OP_ARITHI = 7'b0010011;
  localparam logic [6:0] OP_BR     = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES     = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MINV     = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] FOUR     = XLEN'(4'd4);
  localparam logic [SHW-1:0]  CNT_LAST = SHW'(XLEN-1);
  localparam logic [SHW-1:0]  CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic                   busy_q, busy_d;
  logic [SHW-1:0]         cnt_q, cnt_d;
  logic [2*XLEN-1:0]      acc_q, acc_d;
  logic [XLEN-1:0]        opb_q, opb_d;
  logic [2:0]             f3_q, f3_d;
  logic                   neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [ROB_POS_WID-1:0] rob_q, rob_d;
  logic [XLEN-1:0]        pc4_q, pc4_d;
  logic                   result_q, result_d;
  logic [ROB_POS_WID-1:0] result_rob_pos_q, result_rob_pos_d;
  logic [XLEN-1:0]        result_val_q, result_val_d;
  logic                   result_jump_q, result_jump_d;
  logic [XLEN-1:0]        result_pc_q, result_pc_d;

  logic [XLEN-1:0]        op_b, pc_plus4, pc_plus_imm, alu_out;
  logic signed [XLEN-1:0] sra_out;
  logic [SHW-1:0]         shamt;
  logic                   slt, sltu, taken;
  logic [XLEN-1:0]        base_val, base_pc;
  logic                   base_jump;

  // Single-cycle datapath evaluated straight from the issue inputs.
  always_comb begin
    op_b        = (opcode == OP_ARITH) ? val2 : imm;
    shamt       = op_b[SHW-1:0];
    pc_plus4    = pc + FOUR;
    pc_plus_imm = pc + imm;
    sra_out     = $signed(val1) >>> shamt;
    slt         = $signed(val1) < $signed(op_b);
    sltu        = val1 < op_b;
    case (funct3)
      3'd0:    alu_out = (opcode == OP_ARITH && funct7_alt) ? (val1 - op_b) : (val1 + op_b);
      3'd1:    alu_out = val1 << shamt;
      3'd2:    alu_out = {{(XLEN-1){1'b0}}, slt};
      3'd3:    alu_out = {{(XLEN-1){1'b0}}, sltu};
      3'd4:    alu_out = val1 ^ op_b;
      3'd5:    alu_out = funct7_alt ? sra_out : (val1 >> shamt);
      3'd6:    alu_out = val1 | op_b;
      3'd7:    alu_out = val1 & op_b;
      default: alu_out = ZERO;
    endcase
    case (funct3)
      3'd0:    taken = (val1 == val2);
      3'd1:    taken = (val1 != val2);
      3'd4:    taken = $signed(val1) < $signed(val2);
      3'd5:    taken = $signed(val1) >= $signed(val2);
      3'd6:    taken = val1 < val2;
      3'd7:    taken = val1 >= val2;
      default: taken = 1'b0;
    endcase
    base_val  = ZERO;
    base_jump = 1'b0;
    base_pc   = pc_plus4;
    case (opcode)
      OP_ARITH, OP_ARITHI: base_val = alu_out;
      OP_BR: begin
        base_jump = taken;
        base_pc   = taken ? pc_plus_imm : pc_plus4;
      end
      OP_JAL: begin
        base_val  = pc_plus4;
        base_jump = 1'b1;
        base_pc   = pc_plus_imm;
      end
      OP_JALR: begin
        base_val  = pc_plus4;
        base_jump = 1'b1;
        base_pc   = (val1 + imm) & ~{{(XLEN-1){1'b0}}, 1'b1};
      end
      OP_LUI:   base_val = imm;
      OP_AUIPC: base_val = pc_plus_imm;
      default:  base_val = ZERO;
    endcase
  end

  logic            is_md, sgn_a, sgn_b, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   mul_sum, div_rs;
  logic            div_ge;
  logic [XLEN-1:0] div_diff, div_rem, quo_fix, rem_fix, done_val;
  logic [2*XLEN-1:0] mul_prod;

  // Operand magnitudes and one iteration step of the shared accumulator.
  always_comb begin
    is_md = (opcode == OP_ARITH) && funct7_m;
    if (funct3[2]) begin
      sgn_a = ~funct3[0];
      sgn_b = ~funct3[0];
    end else begin
      sgn_a = (funct3 != 3'd3);
      sgn_b = ~funct3[1];
    end
    a_neg = sgn_a & val1[XLEN-1];
    b_neg = sgn_b & val2[XLEN-1];
    a_mag = a_neg ? -val1 : val1;
    b_mag = b_neg ? -val2 : val2;

    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    div_rs   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge   = div_rs >= {1'b0, opb_q};
    div_diff = div_rs[XLEN-1:0] - opb_q;
    div_rem  = div_ge ? div_diff : div_rs[XLEN-1:0];

    mul_prod = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quo_fix  = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (f3_q)
      3'd0:       done_val = mul_prod[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:       done_val = mul_prod[2*XLEN-1:XLEN];
      3'd4, 3'd5: done_val = quo_fix;
      default:    done_val = rem_fix;
    endcase
  end

  // Next-state and output logic; rdy low holds every register.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    acc_d            = acc_q;
    opb_d            = opb_q;
    f3_d             = f3_q;
    neg_a_d          = neg_a_q;
    neg_b_d          = neg_b_q;
    rob_d            = rob_q;
    pc4_d            = pc4_q;
    result_d         = result_q;
    result_rob_pos_d = result_rob_pos_q;
    result_val_d     = result_val_q;
    result_jump_d    = result_jump_q;
    result_pc_d      = result_pc_q;
    if (!rdy) begin
      state_d = state_q;
    end else if (rollback) begin
      state_d  = S_IDLE;
      result_d = 1'b0;
    end else begin
      result_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (alu_en && is_md) begin
            f3_d  = funct3;
            rob_d = rob_pos;
            pc4_d = pc_plus4;
            cnt_d = {SHW{1'b0}};
            // Divide-by-zero and signed overflow preload the final answer.
            if (!funct3[2]) begin
              state_d = S_MUL;
              acc_d   = {ZERO, b_mag};
              opb_d   = a_mag;
              neg_a_d = a_neg;
              neg_b_d = b_neg;
            end else if (val2 == ZERO) begin
              state_d = S_DONE;
              acc_d   = {val1, ONES};
              neg_a_d = 1'b0;
              neg_b_d = 1'b0;
            end else if (sgn_a && val1 == MINV && val2 == ONES) begin
              state_d = S_DONE;
              acc_d   = {ZERO, val1};
              neg_a_d = 1'b0;
              neg_b_d = 1'b0;
            end else begin
              state_d = S_DIV;
              acc_d   = {ZERO, a_mag};
              opb_d   = b_mag;
              neg_a_d = a_neg;
              neg_b_d = b_neg;
            end
          end else if (alu_en) begin
            result_d         = 1'b1;
            result_rob_pos_d = rob_pos;
            result_val_d     = base_val;
            result_jump_d    = base_jump;
            result_pc_d      = base_pc;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_MUL: begin
          acc_d   = {mul_sum, acc_q[XLEN-1:1]};
          cnt_d   = cnt_q + CNT_ONE;
          state_d = (cnt_q == CNT_LAST) ? S_DONE : S_MUL;
        end
        S_DIV: begin
          acc_d   = {div_rem, acc_q[XLEN-2:0], div_ge};
          cnt_d   = cnt_q + CNT_ONE;
          state_d = (cnt_q == CNT_LAST) ? S_DONE : S_DIV;
        end
        S_DONE: begin
          result_d         = 1'b1;
          result_rob_pos_d = rob_q;
          result_val_d     = done_val;
          result_jump_d    = 1'b0;
          result_pc_d      = pc4_q;
          state_d          = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      busy_q           <= 1'b0;
      cnt_q            <= {SHW{1'b0}};
      acc_q            <= {ZERO, ZERO};
      opb_q            <= ZERO;
      f3_q             <= 3'd0;
      neg_a_q          <= 1'b0;
      neg_b_q          <= 1'b0;
      rob_q            <= {ROB_POS_WID{1'b0}};
      pc4_q            <= ZERO;
      result_q         <= 1'b0;
      result_rob_pos_q <= {ROB_POS_WID{1'b0}};
      result_val_q     <= ZERO;
      result_jump_q    <= 1'b0;
      result_pc_q      <= ZERO;
    end else begin
      state_q          <= state_d;
      busy_q           <= busy_d;
      cnt_q            <= cnt_d;
      acc_q            <= acc_d;
      opb_q            <= opb_d;
      f3_q             <= f3_d;
      neg_a_q          <= neg_a_d;
      neg_b_q          <= neg_b_d;
      rob_q            <= rob_d;
      pc4_q            <= pc4_d;
      result_q         <= result_d;
      result_rob_pos_q <= result_rob_pos_d;
      result_val_q     <= result_val_d;
      result_jump_q    <= result_jump_d;
      result_pc_q      <= result_pc_d;
    end
  end

  assign busy           = busy_q;
  assign result         = result_q;
  assign result_rob_pos = result_rob_pos_q;
  assign result_val     = result_val_q;
  assign result_jump    = result_jump_q;
  assign result_pc      = result_pc_q;

endmodule
